// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message scheduler and the round engine.
//   sched_state_t      : scheduler FSM states (LOAD, EXPAND)
//   WORD_W/BLOCK_WORDS/ROUNDS : datapath geometry
//   K[0:63]            : round constants (consumed by the round engine)
//   rotr/ssig0/ssig1   : schedule helper functions
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS      = 64;

  typedef enum logic {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } sched_state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Accepts the 16 message words of a block (valid_i/M_i, no backpressure),
// echoes them as W0..W15 and then expands W16..W63 on 48 back-to-back cycles.
//
// Handshake: a word is taken on every posedge where valid_i=1; there is no
// ready. The output side is valid-only: w_o/t_o are meaningful only in cycles
// where w_valid_o=1, and the consumer must accept them on that cycle.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-low reset
//   valid_i    M_i carries a message word
//   M_i        32-bit message word, M0 first
//   clr_ovr_i  synchronous clear of overrun_o
//   w_valid_o  w_o/t_o valid
//   w_o        schedule word W[t_o]
//   t_o        round index 0..63
//   done_o     one-cycle pulse with W63
//   busy_o     high on the W16..W63 output cycles (FSM in EXPAND)
//   overrun_o  sticky: a word arrived during expansion and was dropped
module sha256_msg_sched #(
  parameter int ROUNDS      = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] M_i,
  input  logic        clr_ovr_i,
  output logic        w_valid_o,
  output logic [31:0] w_o,
  output logic [5:0]  t_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        overrun_o
);
  import sha256_pkg::*;

  if (ROUNDS != 64) begin : g_bad_rounds
    $error("sha256_msg_sched: ROUNDS must be 64");
  end
  if (BLOCK_WORDS != 16) begin : g_bad_block_words
    $error("sha256_msg_sched: BLOCK_WORDS must be 16");
  end

  localparam logic [5:0] LAST_LOAD_T = 6'(BLOCK_WORDS - 1);
  localparam logic [5:0] LAST_T      = 6'(ROUNDS - 1);

  sched_state_t state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [31:0]  win_q [16];   // win_q[0] is the oldest word, W[t-16]

  logic         shift_en;
  logic [31:0]  shift_in;
  logic [31:0]  w_new;
  logic         out_valid_d;
  logic         done_d;
  logic         busy_d;
  logic         ovr_set;

  // Four-term add wraps mod 2^32 by construction of the 32-bit result.
  assign w_new = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  // Words arriving during expansion are dropped and only flagged.
  assign ovr_set = valid_i && (state_q == EXPAND);

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    shift_en    = 1'b0;
    shift_in    = M_i;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (valid_i) begin
          shift_en    = 1'b1;
          out_valid_d = 1'b1;
          t_d         = t_q + 6'd1;   // word 15 leaves t at 16 for EXPAND
          if (t_q == LAST_LOAD_T) state_d = EXPAND;
        end
      end
      EXPAND: begin
        shift_en    = 1'b1;
        shift_in    = w_new;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        if (t_q == LAST_T) begin
          done_d  = 1'b1;
          t_d     = 6'd0;
          state_d = LOAD;
        end else begin
          t_d = t_q + 6'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q       <= 6'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
      w_valid_o <= 1'b0;
      w_o       <= 32'd0;
      t_o       <= 6'd0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      t_q       <= t_d;
      w_valid_o <= out_valid_d;
      done_o    <= done_d;
      busy_o    <= busy_d;
      overrun_o <= ovr_set | (overrun_o & ~clr_ovr_i);   // set beats clear
      if (shift_en) begin
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15] <= shift_in;
      end
      // w_o/t_o hold between valid cycles.
      if (out_valid_d) begin
        w_o <= shift_in;
        t_o <= t_q;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] M_i;
  logic        clr_ovr_i;
  logic        w_valid_o;
  logic [31:0] w_o;
  logic [5:0]  t_o;
  logic        done_o;
  logic        busy_o;
  logic        overrun_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_t_q[$];
  logic [31:0] gold [64];
  logic [31:0] cap  [64];
  logic [31:0] abc_blk  [16];
  logic [31:0] ones_blk [16];
  bit          mon_en = 1'b0;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .M_i       (M_i),
    .clr_ovr_i (clr_ovr_i),
    .w_valid_o (w_valid_o),
    .w_o       (w_o),
    .t_o       (t_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- golden model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  task automatic build_gold(input logic [31:0] blk [16]);
    for (int t = 0; t < 16; t++) gold[t] = blk[t];
    for (int t = 16; t < 64; t++)
      gold[t] = (rr(gold[t-2], 17) ^ rr(gold[t-2], 19) ^ (gold[t-2] >> 10))
              + gold[t-7]
              + (rr(gold[t-15], 7) ^ rr(gold[t-15], 18) ^ (gold[t-15] >> 3))
              + gold[t-16];
  endtask

  task automatic queue_block(input logic [31:0] blk [16]);
    build_gold(blk);
    for (int t = 0; t < 64; t++) begin
      exp_q.push_back(gold[t]);
      exp_t_q.push_back(32'(t));
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_block(input logic [31:0] blk [16], input int max_gap);
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      repeat (gap) begin
        @(negedge clk);
        valid_i = 1'b0;
      end
      @(negedge clk);
      valid_i = 1'b1;
      M_i     = blk[i];
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 64; i++) cap[i] = 32'hxxxxxxxx;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (w_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, w_valid_o}, 32'd0);
        end else begin
          logic [31:0] e, et;
          e  = exp_q.pop_front();
          et = exp_t_q.pop_front();
          check($sformatf("w[%0d]", et), w_o, e);
          check($sformatf("t_at_%0d", et), {26'd0, t_o}, et);
          check($sformatf("done_at_%0d", et), {31'd0, done_o}, {31'd0, (et == 32'd63)});
          check($sformatf("busy_at_%0d", et), {31'd0, busy_o}, {31'd0, (et >= 32'd16)});
          cap[t_o] = w_o;
        end
      end else begin
        check("done_while_idle", {31'd0, done_o}, 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_w_valid"}, {31'd0, w_valid_o}, 32'd0);
    check({pfx, "_w"},       w_o,                32'd0);
    check({pfx, "_t"},       {26'd0, t_o},       32'd0);
    check({pfx, "_done"},    {31'd0, done_o},    32'd0);
    check({pfx, "_busy"},    {31'd0, busy_o},    32'd0);
    check({pfx, "_overrun"}, {31'd0, overrun_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    M_i       = 32'd0;
    clr_ovr_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      abc_blk[i]  = 32'd0;
      ones_blk[i] = 32'hffffffff;
    end
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    clear_cap();

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 1: "abc" back-to-back, hand-derived schedule words
    queue_block(abc_blk);
    send_block(abc_blk, 0);
    wait_drain();
    check("abc_w0",  cap[0],  32'h61626380);
    check("abc_w15", cap[15], 32'h00000018);
    check("abc_w16", cap[16], 32'h61626380);
    check("abc_w17", cap[17], 32'h000f0000);
    check("abc_w18", cap[18], 32'h7da86405);
    check("abc_w19", cap[19], 32'h600003c6);
    check("abc_overrun", {31'd0, overrun_o}, 32'd0);

    // 2: same block with random 0-3 cycle gaps
    clear_cap();
    queue_block(abc_blk);
    send_block(abc_blk, 3);
    wait_drain();
    check("gap_w16", cap[16], 32'h61626380);
    check("gap_w17", cap[17], 32'h000f0000);

    // 3: word injected at EXPAND t=30, with clear asserted the same cycle
    queue_block(abc_blk);
    send_block(abc_blk, 0);
    repeat (14) @(negedge clk);
    valid_i   = 1'b1;
    M_i       = 32'hdeadbeef;
    clr_ovr_i = 1'b1;
    @(negedge clk);
    valid_i   = 1'b0;
    clr_ovr_i = 1'b0;
    check("ovr_set", {31'd0, overrun_o}, 32'd1);
    wait_drain();
    check("ovr_sticky", {31'd0, overrun_o}, 32'd1);
    @(negedge clk);
    clr_ovr_i = 1'b1;
    @(negedge clk);
    clr_ovr_i = 1'b0;
    check("ovr_clr", {31'd0, overrun_o}, 32'd0);

    // 4: second block's first word sampled exactly at k+49
    clear_cap();
    queue_block(abc_blk);
    send_block(abc_blk, 0);
    repeat (47) @(negedge clk);
    queue_block(ones_blk);
    send_block(ones_blk, 0);
    wait_drain();
    check("b2b_overrun", {31'd0, overrun_o}, 32'd0);
    check("b2b_w16", cap[16], 32'h203ffffc);

    // 5: reset in the middle of expansion
    queue_block(abc_blk);
    send_block(abc_blk, 0);
    repeat (24) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    clear_cap();
    queue_block(abc_blk);
    send_block(abc_blk, 0);
    wait_drain();
    check("rerun_w16", cap[16], 32'h61626380);
    check("rerun_w17", cap[17], 32'h000f0000);
    check("rerun_w18", cap[18], 32'h7da86405);

    // 6: all-ones block exercises 4-term wrap
    clear_cap();
    queue_block(ones_blk);
    send_block(ones_blk, 1);
    wait_drain();
    check("ones_w16", cap[16], 32'h203ffffc);
    check("ones_w17", cap[17], 32'h203ffffc);
    check("ones_overrun", {31'd0, overrun_o}, 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
